dmemory_param: RTL and testbench
================================

// Module: dmemory_param
// PURPOSE
//  Parametrised data memory for the MEM stage, next generation of the word-only dmemory.
//  Adds byte/halfword/word stores and loads with sign or zero extension.
//  Adds a registered one-cycle read port on the rising edge of clock.
//  Adds misalign and range fault detection, and an optional post-reset zero-fill sequencer.
//  Sits between the ALU result/register-file store path and the writeback mux.
// PARAMETERS
//  DEPTH          16384       words of storage; power of 2; word index = (address-BASE_ADDR)>>2
//  ADDR_W         32          byte address width
//  BASE_ADDR      32'h0       byte address of word 0
//  CLEAR_ON_RESET 1           1: zero-fill every word after reset; 0: contents left unchanged
// PORTS
//  clock        in   1       system clock; all logic on the rising edge
//  reset_n      in   1       synchronous reset, active low
//  mem_read     in   1       load request, sampled on the rising edge
//  mem_write    in   1       store request, sampled on the rising edge
//  size         in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  load_unsigned in  1       1: zero-extend sub-word loads; 0: sign-extend
//  address      in   ADDR_W  byte address
//  write_data   in   32      store data; byte/half taken from the low bits
//  read_data    out  32      extended load result, registered
//  read_valid   out  1       1-cycle pulse: read_data updated this cycle
//  busy         out  1       1 while zero-filling; requests ignored
//  fault        out  1       1-cycle pulse: the previous request was suppressed
//  fault_cause  out  2       01 misaligned, 10 out of range; held until the next fault
// BEHAVIOUR
//  Reset (reset_n=0 at a rising edge) sets: read_data=0, read_valid=0, fault=0, fault_cause=00, clr_ptr=0.
//  Reset also sets state=CLEAR and busy=1 if CLEAR_ON_RESET=1; otherwise state=READY and busy=0.
//  States:
//   - CLEAR: writes 0 to word clr_ptr and increments clr_ptr each cycle.
//   - CLEAR -> READY: on the cycle clr_ptr==DEPTH-1 is written; busy drops on the following cycle, so the fill takes exactly DEPTH cycles.
//   - READY: serves requests; never leaves READY except through reset.
//  Reset asserted mid-CLEAR restarts the fill at word 0. Reset mid-read: read_valid=0 on the next cycle.
//  A request is accepted only in READY. In CLEAR, mem_read/mem_write are ignored: no write, no read_valid, no fault.
//  Lanes are little-endian. Lane = address[1:0] for a byte, address[1] for a half.
//  Store byte: write_data[7:0] goes to the selected lane only; other lanes are unchanged.
//  Store half: write_data[15:0] goes to lanes {a1,0}; the other half is unchanged.
//  Store word: all four lanes are written.
//  Load latency is 1 cycle: request at edge N -> read_data and read_valid=1 after edge N+1.
//   - Byte: the selected lane, extended to 32 bits.
//   - Half: the selected half, extended to 32 bits.
//   - Word: passed through unchanged.
//  read_data holds its value when no load completes.
//  Misaligned access is suppressed (no write, read_valid=0):
//   - half with address[0]=1;
//   - word with address[1:0]!=0.
//   The result is fault=1 for 1 cycle and fault_cause=01.
//  Out of range: address<BASE_ADDR or word index>=DEPTH -> suppressed, fault=1, fault_cause=10.
//  If an access is both misaligned and out of range, cause=01 takes priority.
//  mem_read and mem_write both high: the access is a store only; read_valid=0.
//  Back-to-back requests are accepted every cycle.
//  A load the cycle after a store to the same word returns the stored data (write completes at edge N).
//  A store and a load in the same edge cannot collide, because both-high means store only.
//  Storage is an inferred array with byte-lane write enables and a synchronous read. No inverted clock.
// TESTING
//  1. Reset with CLEAR_ON_RESET=1, DEPTH=16 -> busy=1 for exactly 16 cycles; then loading word 5 returns 0x00000000.
//  2. sw 0x11223344 @0x8, then lb @0xB -> 0x00000011; lbu @0x8 -> 0x00000044; lh @0xA -> 0x00001122.
//  3. sw 0xFFFFFFFF @0x4, then sb 0x80 @0x5 -> lw @0x4 = 0xFFFF80FF; lb @0x5 = 0xFFFFFF80; lbu = 0x00000080.
//  4. lw @0x6 -> fault=1, cause=01, read_valid=0. sh @0x3 -> fault=1, memory unchanged. lh @0x2 -> fault=0.
//  5. lw @ BASE_ADDR+4*DEPTH -> fault=1, cause=10; read_data keeps its previous value.
//  6. Assert reset_n=0 at clear cycle 7, release -> busy lasts a full DEPTH cycles again. Requests during CLEAR -> no effect.

Source files
------------

// File: rtl/dmemory_param.sv
// dmemory_param: MEM-stage data memory with byte/half/word access,
// sign/zero-extended loads, misalign/range faults and post-reset zero-fill.
module dmemory_param #(
  parameter int unsigned       DEPTH          = 16384,
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  clr_ptr;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_off;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              misaligned;
  logic              req;
  logic              bad;
  logic              wr_ok;
  logic              rd_ok;

  logic [3:0]        lane_we;
  logic [31:0]       lane_wd;
  logic [3:0]        mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wd;

  // Load pipeline: stage 1 holds the raw word and its access attributes
  logic [31:0]       rd_word;
  logic              p_valid;
  logic [1:0]        p_size;
  logic [1:0]        p_lane;
  logic              p_uns;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ext_data;

  logic              busy_nxt;
  logic              fault_nxt;
  logic [1:0]        cause_nxt;
  logic              p_valid_nxt;
  logic              read_valid_nxt;
  logic [31:0]       read_data_nxt;

  // Address decode, fault classification and request qualification
  always_comb begin
    offset     = address - BASE_ADDR;
    word_off   = offset >> 2;
    idx        = word_off[IDX_W-1:0];
    in_range   = (address >= BASE_ADDR) && (word_off < ADDR_W'(DEPTH));
    misaligned = ((size == 2'b01) && address[0]) ||
                 (size[1] && (address[1:0] != 2'b00));
    req        = (state == ST_READY) && (mem_read || mem_write);
    bad        = req && (misaligned || !in_range);
    wr_ok      = (state == ST_READY) && mem_write && !misaligned && in_range;
    rd_ok      = (state == ST_READY) && mem_read && !mem_write && !misaligned && in_range;
  end

  // Byte-lane enables and replicated store data; zero-fill owns the port in CLEAR
  always_comb begin
    lane_we = 4'b1111;
    lane_wd = write_data;
    case (size)
      2'b00: begin
        lane_we = 4'b0001 << address[1:0];
        lane_wd = {4{write_data[7:0]}};
      end
      2'b01: begin
        lane_we = address[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{write_data[15:0]}};
      end
      default: begin
        lane_we = 4'b1111;
        lane_wd = write_data;
      end
    endcase

    mem_we  = 4'b0000;
    mem_idx = idx;
    mem_wd  = lane_wd;
    if (!reset_n) begin
      mem_we = 4'b0000;
    end else if (state == ST_CLEAR) begin
      mem_we  = 4'b1111;
      mem_idx = clr_ptr;
      mem_wd  = 32'h0;
    end else if (wr_ok) begin
      mem_we = lane_we;
    end
  end

  // Storage array: per-lane write enables
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  // Synchronous read of the addressed word
  always_ff @(posedge clock) begin
    if (rd_ok) rd_word <= mem[idx];
  end

  // State register and fill pointer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_ptr <= clr_ptr + IDX_W'(1);
    end
  end

  // Next state: the fill ends on the cycle the last word is written
  always_comb begin
    state_nxt = state;
    if ((state == ST_CLEAR) && (clr_ptr == IDX_W'(DEPTH - 1))) state_nxt = ST_READY;
  end

  // Output next-values: extension of the fetched word, fault reporting, busy
  always_comb begin
    byte_sel = rd_word[{p_lane, 3'b000} +: 8];
    half_sel = p_lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (p_size)
      2'b00:   ext_data = {{24{~p_uns & byte_sel[7]}}, byte_sel};
      2'b01:   ext_data = {{16{~p_uns & half_sel[15]}}, half_sel};
      default: ext_data = rd_word;
    endcase

    busy_nxt       = (state_nxt == ST_CLEAR);
    fault_nxt      = bad;
    cause_nxt      = fault_cause;
    if (bad) cause_nxt = misaligned ? 2'b01 : 2'b10;
    p_valid_nxt    = rd_ok;
    read_valid_nxt = p_valid;
    read_data_nxt  = p_valid ? ext_data : read_data;
  end

  // Output and load-pipeline registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy        <= CLEAR_ON_RESET;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      read_valid  <= 1'b0;
      read_data   <= 32'h0;
      p_valid     <= 1'b0;
      p_size      <= 2'b10;
      p_lane      <= 2'b00;
      p_uns       <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      fault       <= fault_nxt;
      fault_cause <= cause_nxt;
      read_valid  <= read_valid_nxt;
      read_data   <= read_data_nxt;
      p_valid     <= p_valid_nxt;
      if (rd_ok) begin
        p_size <= size;
        p_lane <= address[1:0];
        p_uns  <= load_unsigned;
      end
    end
  end

endmodule

// File: tb/tb_dmemory_param.sv
// Directed testbench for dmemory_param (DEPTH=16, zero-fill on reset).
module tb_dmemory_param;

  logic        clock;
  logic        reset_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_cause;

  int errors = 0;
  int checks = 0;
  int cnt;
  logic leak;

  dmemory_param #(
    .DEPTH(16), .ADDR_W(32), .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .address(address),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
    .busy(busy), .fault(fault), .fault_cause(fault_cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one request for one rising edge, return at the following negedge
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns;
    address = a; write_data = d;
    @(posedge clock);
    @(negedge clock);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 1'b1, sz, 1'b0, a, d);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] exp);
    issue(1'b1, 1'b0, sz, uns, a, 32'h0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    @(negedge clock);
    chk({tag, ".valid"}, 32'(read_valid), 32'd1);
    chk({tag, ".data"}, read_data, exp);
  endtask

  task automatic bad_access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [1:0] cause, input logic [31:0] prev);
    issue(rd, wr, sz, 1'b0, a, 32'h5555_5555);
    chk({tag, ".fault"}, 32'(fault), 32'd1);
    chk({tag, ".cause"}, 32'(fault_cause), 32'(cause));
    @(negedge clock);
    chk({tag, ".pulse"}, 32'(fault), 32'd0);
    chk({tag, ".valid"}, 32'(read_valid), 32'd0);
    chk({tag, ".hold"}, read_data, prev);
  endtask

  // Count busy cycles from the sample after the last reset edge, watching for leaked requests
  task automatic count_clear(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cnt = 1; leak = 1'b0;
    mem_read = rd; mem_write = wr; size = 2'b10; address = a; write_data = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (fault || read_valid) leak = 1'b1;
      if (!busy) break;
      cnt++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clock);
    if (fault || read_valid) leak = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b10;
    load_unsigned = 1'b0; address = 32'h0; write_data = 32'h0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.read_data", read_data, 32'h0);
    chk("rst.read_valid", 32'(read_valid), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.cause", 32'(fault_cause), 32'd0);

    // Zero-fill lasts DEPTH cycles; misaligned reads during it are ignored
    reset_n = 1'b1;
    count_clear(1'b1, 1'b0, 32'h6, 32'h0);
    chk("fill.cycles", 32'(cnt), 32'd16);
    chk("fill.ignored", 32'(leak), 32'd0);
    load("fill.lw5", 2'b10, 1'b0, 32'h14, 32'h0);

    // Sub-word loads from a stored word
    store("sw8", 2'b10, 32'h8, 32'h1122_3344);
    load("lb_b", 2'b00, 1'b0, 32'hB, 32'h0000_0011);
    load("lbu_8", 2'b00, 1'b1, 32'h8, 32'h0000_0044);
    load("lh_a", 2'b01, 1'b0, 32'hA, 32'h0000_1122);

    // Byte and half stores merge into an existing word
    store("sw4", 2'b10, 32'h4, 32'hFFFF_FFFF);
    store("sb5", 2'b00, 32'h5, 32'hABCD_EF80);
    load("lw4a", 2'b10, 1'b0, 32'h4, 32'hFFFF_80FF);
    load("lb5", 2'b00, 1'b0, 32'h5, 32'hFFFF_FF80);
    load("lbu5", 2'b00, 1'b1, 32'h5, 32'h0000_0080);
    store("sh6", 2'b01, 32'h6, 32'h1234_8001);
    load("lw4b", 2'b10, 1'b0, 32'h4, 32'h8001_80FF);
    load("lh6", 2'b01, 1'b0, 32'h6, 32'hFFFF_8001);
    load("lhu6", 2'b01, 1'b1, 32'h6, 32'h0000_8001);

    // Misaligned accesses
    bad_access("lw6", 1'b1, 1'b0, 2'b10, 32'h6, 2'b01, 32'h0000_8001);
    bad_access("sh3", 1'b0, 1'b1, 2'b01, 32'h3, 2'b01, 32'h0000_8001);
    load("lw0", 2'b10, 1'b0, 32'h0, 32'h0);
    load("lh2", 2'b01, 1'b0, 32'h2, 32'h0);

    // Out of range, cause priority, cause held across good accesses
    load("lw8", 2'b10, 1'b0, 32'h8, 32'h1122_3344);
    bad_access("lw40", 1'b1, 1'b0, 2'b10, 32'h40, 2'b10, 32'h1122_3344);
    load("lw8b", 2'b10, 1'b0, 32'h8, 32'h1122_3344);
    chk("cause.held", 32'(fault_cause), 32'd2);
    bad_access("lh41", 1'b1, 1'b0, 2'b01, 32'h41, 2'b01, 32'h1122_3344);

    // Read and write together is a store only
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFE_BABE);
    @(negedge clock);
    chk("rw.valid", 32'(read_valid), 32'd0);
    load("lwC", 2'b10, 1'b0, 32'hC, 32'hCAFE_BABE);

    // Back-to-back store then load of the same word
    mem_write = 1'b1; mem_read = 1'b0; size = 2'b10; address = 32'h10; write_data = 32'h0BAD_F00D;
    @(posedge clock); #1;
    mem_write = 1'b0; mem_read = 1'b1;
    @(posedge clock); #1;
    mem_read = 1'b0;
    @(posedge clock); #1;
    chk("b2b.valid", 32'(read_valid), 32'd1);
    chk("b2b.data", read_data, 32'h0BAD_F00D);
    @(negedge clock);

    // Reset in the middle of the fill restarts it; stores during the fill are ignored
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (7) @(negedge clock);
    chk("mid.busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid.rst_valid", 32'(read_valid), 32'd0);
    reset_n = 1'b1;
    count_clear(1'b0, 1'b1, 32'h0, 32'h1234_5678);
    chk("refill.cycles", 32'(cnt), 32'd16);
    chk("refill.ignored", 32'(leak), 32'd0);
    load("refill.lw0", 2'b10, 1'b0, 32'h0, 32'h0);
    load("refill.lw8", 2'b10, 1'b0, 32'h8, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
